// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - multi-cycle wide adder sequencing word pairs through one CLA
// Optional subtract mode is compiled in with WIDE_ADD_SUB_EN.

module carry_look_ahead_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int GROUPS = (WIDTH + 3) / 4;
  localparam int PW     = GROUPS * 4;

  logic [PW-1:0] g;
  logic [PW-1:0] p;
  logic [PW:0]   c;
  logic [GROUPS:0] gc;

  // 4-bit lookahead groups; group carries chain between groups
  always_comb begin
    g = '0;
    p = '0;
    g[WIDTH-1:0] = in1 & in2;
    p[WIDTH-1:0] = in1 ^ in2;
    c  = '0;
    gc = '0;
    gc[0] = carry_in;
    for (int k = 0; k < GROUPS; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      gc[k+1]  = g[4*k+3] | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    c[PW] = gc[GROUPS];
  end

  assign sum       = p[WIDTH-1:0] ^ c[WIDTH-1:0];
  assign carry_out = c[WIDTH];

endmodule

module wide_add_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [DATA_WIDTH*WORDS-1:0] a,
  input  logic [DATA_WIDTH*WORDS-1:0] b,
  input  logic                        cin,
`ifdef WIDE_ADD_SUB_EN
  input  logic                        sub,
`endif
  output logic                        busy,
  output logic                        done,
  output logic [DATA_WIDTH*WORDS-1:0] result,
  output logic                        cout
);

  localparam int W     = DATA_WIDTH * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [IDX_W-1:0] idx;
  logic             carry_reg;
`ifdef WIDE_ADD_SUB_EN
  logic             sub_reg;
`endif

  logic [DATA_WIDTH-1:0] cla_in1;
  logic [DATA_WIDTH-1:0] cla_in2;
  logic [DATA_WIDTH-1:0] cla_sum;
  logic                  cla_carry_out;

  assign cla_in1 = a_reg[idx*DATA_WIDTH +: DATA_WIDTH];
`ifdef WIDE_ADD_SUB_EN
  // subtraction is a + ~b + 1; the +1 comes from the forced initial carry
  assign cla_in2 = sub_reg ? ~b_reg[idx*DATA_WIDTH +: DATA_WIDTH]
                           :  b_reg[idx*DATA_WIDTH +: DATA_WIDTH];
`else
  assign cla_in2 = b_reg[idx*DATA_WIDTH +: DATA_WIDTH];
`endif

  carry_look_ahead_adder #(
    .WIDTH(DATA_WIDTH)
  ) u_cla (
    .in1      (cla_in1),
    .in2      (cla_in2),
    .carry_in (carry_reg),
    .sum      (cla_sum),
    .carry_out(cla_carry_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      idx       <= '0;
      carry_reg <= 1'b0;
`ifdef WIDE_ADD_SUB_EN
      sub_reg   <= 1'b0;
`endif
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            idx   <= '0;
`ifdef WIDE_ADD_SUB_EN
            sub_reg   <= sub;
            carry_reg <= sub ? 1'b1 : cin;
`else
            carry_reg <= cin;
`endif
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          result[idx*DATA_WIDTH +: DATA_WIDTH] <= cla_sum;
          carry_reg <= cla_carry_out;
          idx       <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            cout  <= cla_carry_out;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb/tb_wide_add_sequencer.sv - scoreboard bench for wide_add_sequencer

module tb_wide_add_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] a = '0;
  logic [127:0] b = '0;
  logic         cin = 1'b0;
`ifdef WIDE_ADD_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [127:0] result;
  logic         cout;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [128:0] exp_q[$];

  wide_add_sequencer #(
    .DATA_WIDTH(32),
    .WORDS(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef WIDE_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .result(result),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic pop_compare(input string tag);
    logic [128:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 129'd0, 129'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, {cout, result}, e);
    end
  endtask

  task automatic wait_done(input string tag, output int cyc, output int bcnt);
    cyc = 1;
    bcnt = 0;
    while (!done && cyc < 30) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    if (!done) check({tag, "_timeout"}, 129'd0, 129'd1);
  endtask

  task automatic run_op(input string tag, input logic [127:0] ta, input logic [127:0] tb_v,
                        input logic tcin, input logic tsub);
    int cyc;
    int bcnt;
    logic [128:0] e;
    @(negedge clk);
    start = 1'b1;
    a = ta;
    b = tb_v;
    cin = tcin;
`ifdef WIDE_ADD_SUB_EN
    sub = tsub;
`endif
    if (tsub) e = {1'b0, ta} + {1'b0, ~tb_v} + 129'd1;
    else      e = {1'b0, ta} + {1'b0, tb_v} + {128'd0, tcin};
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = ~ta;
    b = ~tb_v;
    cin = ~tcin;
    wait_done(tag, cyc, bcnt);
    check({tag, "_latency"}, 129'(cyc), 129'd5);
    check({tag, "_busy_cycles"}, 129'(bcnt), 129'd4);
    pop_compare(tag);
    @(negedge clk);
    check({tag, "_done_single"}, {128'd0, done}, 129'd0);
    check({tag, "_held"}, {cout, result}, e);
  endtask

  initial begin
    int cyc;
    int bcnt;
    int d0;
    logic [127:0] ones;
    ones = '1;

    #12;
    check("reset_busy", {128'd0, busy}, 129'd0);
    check("reset_done", {128'd0, done}, 129'd0);
    check("reset_out", {cout, result}, 129'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("t1_small", 128'd1, 128'd2, 1'b0, 1'b0);
    run_op("t2_ripple", 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, 1'b0);
    run_op("t3_allones", ones, 128'd0, 1'b1, 1'b0);
    run_op("t3_topbit", 128'h80000000_00000000_00000000_00000000,
           128'h80000000_00000000_00000000_00000000, 1'b0, 1'b0);

    // start held high through RUN and DONE; only re-accepted from IDLE
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    a = 128'd1;
    b = 128'd1;
    cin = 1'b0;
`ifdef WIDE_ADD_SUB_EN
    sub = 1'b0;
`endif
    exp_q.push_back(129'd2);
    @(negedge clk);
    a = 128'd5;
    b = 128'd5;
    exp_q.push_back(129'd10);
    wait_done("t4_first", cyc, bcnt);
    check("t4_first_latency", 129'(cyc), 129'd5);
    pop_compare("t4_first");
    @(negedge clk);
    check("t4_idle_gap", {128'd0, busy}, 129'd0);
    @(negedge clk);
    check("t4_reaccept", {128'd0, busy}, 129'd1);
    start = 1'b0;
    wait_done("t4_second", cyc, bcnt);
    pop_compare("t4_second");
    @(negedge clk);
    #1;
    check("t4_done_count", 129'(done_cnt - d0), 129'd2);

    // asynchronous abort mid-RUN
    @(negedge clk);
    start = 1'b1;
    a = ones;
    b = ones;
    cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_abort_busy", {128'd0, busy}, 129'd0);
    check("t5_abort_done", {128'd0, done}, 129'd0);
    check("t5_abort_out", {cout, result}, 129'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("t5_after", 128'd7, 128'd8, 1'b0, 1'b0);

`ifdef WIDE_ADD_SUB_EN
    run_op("t6_borrow", 128'd5, 128'd7, 1'b0, 1'b1);
    run_op("t6_noborrow", 128'd7, 128'd5, 1'b0, 1'b1);
    check("t6_borrow_const", {1'b0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE},
          {1'b0, 128'd5 - 128'd7});
    run_op("t6_add_mode", 128'd9, 128'd6, 1'b1, 1'b0);
`endif

    check("queue_empty", 129'(exp_q.size()), 129'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
